// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, polarity constants, FSM states, total helpers
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam bit ACTIVE_LOW = 1'b0;
  localparam bit ACTIVE_HIGH = 1'b1;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction
endpackage

// File: rtl/timing_axis.sv
// timing_axis: one raster axis (counter, wrap, registered sync, upcoming active decode)
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP = DEF_H_FP,
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP = DEF_H_BP,
  parameter bit POL = ACTIVE_LOW,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance,
  input  logic         load,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync,
  output logic         in_active
);
  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  logic [W-1:0] nxt;
  assign wrap = count == W'(TOTAL - 1);
  assign nxt = advance ? (wrap ? '0 : count + W'(1)) : count;
  assign in_active = nxt < W'(ACTIVE);
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      sync <= ~POL;
    end else begin
      count <= nxt;
      if (load) sync <= (nxt >= W'(ACTIVE + FP) && nxt < W'(ACTIVE + FP + SYNC)) ? POL : ~POL;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with syncs, data enable, strobes and frame counter
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit H_POL = ACTIVE_LOW,
  parameter bit V_POL = ACTIVE_LOW,
  parameter int CNT_W = 10,
  parameter int FRAME_W = 8
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Enable,
  output logic [CNT_W-1:0]   o_col_num,
  output logic [CNT_W-1:0]   o_row_num,
  output logic               o_h_sync,
  output logic               o_v_sync,
  output logic               o_active,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic [FRAME_W-1:0] o_frame_count
);
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int MAX_TOTAL = H_TOTAL > V_TOTAL ? H_TOTAL : V_TOTAL;
  if ((longint'(1) << CNT_W) < longint'(MAX_TOTAL) || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
      H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
    $error("vga_timing_gen: CNT_W too narrow or zero-length interval");
  end
  state_t state, state_nxt;
  logic h_adv, h_wrap, v_wrap, h_act, v_act, line_nxt, frame_nxt;
  assign h_adv = i_Enable & (state == RUN);
  timing_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .W(CNT_W)) u_h (
    .clk(i_Clk), .reset(i_Reset), .advance(h_adv), .load(i_Enable),
    .count(o_col_num), .wrap(h_wrap), .sync(o_h_sync), .in_active(h_act)
  );
  timing_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .W(CNT_W)) u_v (
    .clk(i_Clk), .reset(i_Reset), .advance(h_adv & h_wrap), .load(i_Enable),
    .count(o_row_num), .wrap(v_wrap), .sync(o_v_sync), .in_active(v_act)
  );
  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = (state == IDLE && i_Enable) ? RUN : state;
    line_nxt = i_Enable & (state == IDLE | h_wrap);
    frame_nxt = i_Enable & (state == IDLE | (h_wrap & v_wrap));
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_active <= 1'b0;
      o_line_start <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_count <= '0;
    end else begin
      o_line_start <= line_nxt;
      o_frame_start <= frame_nxt;
      if (i_Enable) o_active <= h_act & v_act;
      if (h_adv & h_wrap & v_wrap) o_frame_count <= o_frame_count + FRAME_W'(1);
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: table vectors, corner sequences and randomized model checks on two rasters
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0, en0, rst1, en1;
  logic [9:0] col0, row0;
  logic hs0, vs0, act0, ls0, fs0;
  logic [7:0] fc0;
  logic [3:0] col1, row1;
  logic hs1, vs1, act1, ls1, fs1;
  logic [1:0] fc1;
  vga_timing_gen u_d0 (
    .i_Clk(clk), .i_Reset(rst0), .i_Enable(en0), .o_col_num(col0), .o_row_num(row0),
    .o_h_sync(hs0), .o_v_sync(vs0), .o_active(act0), .o_line_start(ls0),
    .o_frame_start(fs0), .o_frame_count(fc0)
  );
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(4), .FRAME_W(2)
  ) u_d1 (
    .i_Clk(clk), .i_Reset(rst1), .i_Enable(en1), .o_col_num(col1), .o_row_num(row1),
    .o_h_sync(hs1), .o_v_sync(vs1), .o_active(act1), .o_line_start(ls1),
    .o_frame_start(fs1), .o_frame_count(fc1)
  );
  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic hs, vs, act, ls, fs;
    logic [7:0] fc;
  } obs_t;
  typedef struct {
    bit rst;
    bit en;
    obs_t exp;
  } vec_t;
  int total = 0;
  int bad = 0;
  int ha[2] = '{640, 4};
  int hf[2] = '{16, 1};
  int hsw[2] = '{96, 2};
  int hb[2] = '{48, 1};
  int va[2] = '{480, 3};
  int vf[2] = '{10, 1};
  int vsw[2] = '{2, 1};
  int vb[2] = '{33, 1};
  bit pol[2] = '{1'b0, 1'b1};
  int fw[2] = '{8, 2};
  bit started[2];
  bit last_en[2];
  longint t[2];
  function automatic obs_t model_obs(int d);
    obs_t e;
    longint ht, vt, c, r;
    ht = ha[d] + hf[d] + hsw[d] + hb[d];
    vt = va[d] + vf[d] + vsw[d] + vb[d];
    e = '0;
    e.hs = ~pol[d];
    e.vs = ~pol[d];
    if (!started[d]) return e;
    c = t[d] % ht;
    r = (t[d] / ht) % vt;
    e.col = 10'(c);
    e.row = 10'(r);
    if (c >= ha[d] + hf[d] && c < ha[d] + hf[d] + hsw[d]) e.hs = pol[d];
    if (r >= va[d] + vf[d] && r < va[d] + vf[d] + vsw[d]) e.vs = pol[d];
    e.act = c < ha[d] && r < va[d];
    e.ls = last_en[d] && c == 0;
    e.fs = e.ls && r == 0;
    e.fc = 8'((t[d] / (ht * vt)) % (longint'(1) << fw[d]));
    return e;
  endfunction
  function automatic obs_t actual(int d);
    return d == 1 ? obs_t'({6'd0, col1, 6'd0, row1, hs1, vs1, act1, ls1, fs1, 6'd0, fc1})
                  : obs_t'({col0, row0, hs0, vs0, act0, ls0, fs0, fc0});
  endfunction
  function automatic obs_t mk(int c, int r, bit hs, bit vs, bit act, bit ls, bit fs, int fc);
    obs_t o;
    o.col = 10'(c);
    o.row = 10'(r);
    o.hs = hs;
    o.vs = vs;
    o.act = act;
    o.ls = ls;
    o.fs = fs;
    o.fc = 8'(fc);
    return o;
  endfunction
  task automatic check(input string name, input obs_t got, input obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask
  task automatic chk_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask
  task automatic step(input int d, input bit r, input bit e);
    if (r) begin
      started[d] = 1'b0;
      last_en[d] = 1'b0;
    end else if (e) begin
      if (!started[d]) begin
        started[d] = 1'b1;
        t[d] = 0;
      end else t[d]++;
      last_en[d] = 1'b1;
    end else last_en[d] = 1'b0;
  endtask
  task automatic cycle(input bit r0, input bit e0, input bit r1, input bit e1);
    rst0 = r0;
    en0 = e0;
    rst1 = r1;
    en1 = e1;
    @(posedge clk);
    step(0, r0, e0);
    step(1, r1, e1);
    @(negedge clk);
    check("model_vga", actual(0), model_obs(0));
    check("model_small", actual(1), model_obs(1));
  endtask
  task automatic c0(input bit r, input bit e);
    cycle(r, e, $urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0);
  endtask
  task automatic c1(input bit r, input bit e);
    cycle(1'b0, 1'b0, r, e);
  endtask
  task automatic run_to(input int c, input int r, input int bound);
    int n = 0;
    while (!(col0 == 10'(c) && row0 == 10'(r)) && n < bound) begin
      c0(1'b0, 1'b1);
      n++;
    end
    chk_int("reach_position", int'(col0 == 10'(c) && row0 == 10'(r)), 1);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t vecs[10];
    obs_t rst_obs;
    int hs_n, hs_first, hs_last, act_fall, ls_n, last_ls, last_fs, nfs, hs_hi;
    int fcs_exp[6];
    fcs_exp = '{0, 1, 2, 3, 0, 1};
    rst_obs = mk(0, 0, 1, 1, 0, 0, 0, 0);
    vecs[0] = '{1'b1, 1'b1, rst_obs};
    vecs[1] = '{1'b1, 1'b1, rst_obs};
    vecs[2] = '{1'b1, 1'b1, rst_obs};
    vecs[3] = '{1'b0, 1'b1, mk(0, 0, 1, 1, 1, 1, 1, 0)};
    vecs[4] = '{1'b0, 1'b1, mk(1, 0, 1, 1, 1, 0, 0, 0)};
    vecs[5] = '{1'b0, 1'b0, mk(1, 0, 1, 1, 1, 0, 0, 0)};
    vecs[6] = '{1'b0, 1'b1, mk(2, 0, 1, 1, 1, 0, 0, 0)};
    vecs[7] = '{1'b1, 1'b0, rst_obs};
    vecs[8] = '{1'b0, 1'b0, rst_obs};
    vecs[9] = '{1'b0, 1'b1, mk(0, 0, 1, 1, 1, 1, 1, 0)};
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      c0(vecs[i].rst, vecs[i].en);
      check("vec", actual(0), vecs[i].exp);
    end
    hs_n = 0;
    hs_first = -1;
    hs_last = -1;
    act_fall = -1;
    ls_n = 0;
    for (int i = 0; i < 800; i++) begin
      c0(1'b0, 1'b1);
      if (!hs0) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(col0);
        hs_last = int'(col0);
      end
      if (!act0 && act_fall < 0) act_fall = int'(col0);
      if (ls0) ls_n++;
    end
    chk_int("hsync_width", hs_n, 96);
    chk_int("hsync_first_col", hs_first, 656);
    chk_int("hsync_last_col", hs_last, 751);
    chk_int("active_fall_col", act_fall, 640);
    chk_int("line_start_count", ls_n, 1);
    chk_int("line_wrap_col", int'(col0), 0);
    chk_int("line_wrap_row", int'(row0), 1);
    run_to(700, 2, 3000);
    for (int i = 0; i < 5; i++) begin
      c0(1'b0, 1'b0);
      chk_int("pause_col", int'(col0), 700);
      chk_int("pause_row", int'(row0), 2);
      chk_int("pause_strobes", int'(ls0 | fs0), 0);
    end
    c0(1'b0, 1'b1);
    chk_int("resume_col", int'(col0), 701);
    run_to(300, 3, 3000);
    c0(1'b1, 1'b1);
    check("midframe_reset", actual(0), rst_obs);
    c0(1'b0, 1'b1);
    check("restart_first", actual(0), mk(0, 0, 1, 1, 1, 1, 1, 0));
    c0(1'b0, 1'b1);
    check("restart_second", actual(0), mk(1, 0, 1, 1, 1, 0, 0, 0));
    for (int i = 0; i < 3000; i++) cycle($urandom_range(0, 999) == 0, $urandom_range(0, 4) != 0,
                                         $urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0);
    c1(1'b1, 1'b0);
    last_ls = -1;
    last_fs = -1;
    nfs = 0;
    hs_hi = 0;
    for (int i = 0; i < 241; i++) begin
      c1(1'b0, 1'b1);
      if (ls1) begin
        if (last_ls >= 0) chk_int("small_line_period", i - last_ls, 8);
        last_ls = i;
      end
      if (fs1) begin
        if (last_fs >= 0) chk_int("small_frame_period", i - last_fs, 48);
        if (nfs < 6) chk_int("small_frame_count", int'(fc1), fcs_exp[nfs]);
        nfs++;
        last_fs = i;
      end
      if (hs1) begin
        hs_hi++;
        chk_int("small_hsync_col", int'(col1 >= 5 && col1 <= 6), 1);
      end
      if (vs1) chk_int("small_vsync_row", int'(row1), 4);
    end
    chk_int("small_frame_starts", nfs, 6);
    chk_int("small_hsync_cycles", hs_hi, 60);
    for (int i = 0; i < 2000; i++) c1($urandom_range(0, 199) == 0, $urandom_range(0, 5) != 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the fixed 640x480 sync generator.
- Adds explicit front porch, sync and back porch intervals, selectable sync polarity, a data-enable output, line and frame start strobes, a frame counter, a clock enable, and synchronous reset.
- Sits between the pixel clock domain and the Pong renderer (paddles, ball, score); all drawing logic keys off its counters and strobes.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, asserted hsync level (0 = active-low)
- V_POL, 0, asserted vsync level (0 = active-low)
- CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 8, frame counter width

Ports:
- i_Clk  in  1  pixel clock
- i_Reset  in  1  synchronous, active-high reset
- i_Enable  in  1  advance raster when high
- o_col_num  out  CNT_W  current column, 0..H_TOTAL-1
- o_row_num  out  CNT_W  current row, 0..V_TOTAL-1
- o_h_sync  out  1  horizontal sync, polarity per H_POL
- o_v_sync  out  1  vertical sync, polarity per V_POL
- o_active  out  1  high when col < H_ACTIVE and row < V_ACTIVE
- o_line_start  out  1  one-cycle strobe at col 0
- o_frame_start  out  1  one-cycle strobe at col 0, row 0
- o_frame_count  out  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Clock and reset: the block uses one clock, i_Clk. Reset i_Reset is synchronous and active-high.
- Every output is a register. In any cycle, decoded outputs describe the position currently shown on o_col_num/o_row_num; the decode is computed from the next position, giving zero lag between counters and decode.
- Two-state FSM:
  - IDLE: entered on reset.
  - RUN: entered on the first i_Enable=1 edge after IDLE.
- Reset values (held while i_Reset=1, FSM in IDLE):
  - col = 0, row = 0, frame_count = 0
  - o_active = 0, o_line_start = 0, o_frame_start = 0
  - o_h_sync = ~H_POL, o_v_sync = ~V_POL
- IDLE -> RUN (edge with i_Enable=1):
  - Counters stay at (0,0).
  - Outputs load the decode for (0,0): active = 1, line_start = 1, frame_start = 1, syncs deasserted.
  - frame_count is unchanged.
- RUN, edge with i_Enable=1:
  - col < H_TOTAL-1: col+1.
  - col = H_TOTAL-1: col = 0 and row+1, or row = 0 if row = V_TOTAL-1.
  - Transition (H_TOTAL-1, V_TOTAL-1) -> (0,0): frame_count+1 and frame_start = 1.
- Sync decode:
  - hsync asserted iff H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted iff V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC; it changes only together with a row change at col 0.
- i_Enable=0: counters, syncs, o_active and frame_count hold; o_line_start and o_frame_start are forced to 0 (no repeated strobes); FSM state holds.
- Reset mid-frame: takes priority over i_Enable. Values return to reset on the next edge. The raster restarts at (0,0) with frame_start on the first enabled edge after release.
- Width rules:
  - Comparisons use CNT_W unsigned arithmetic.
  - Counters never reach H_TOTAL or V_TOTAL.
  - frame_count wraps 2^FRAME_W-1 -> 0 silently.
- Static check: elaboration fails (generate-time error) if 2^CNT_W < max(H_TOTAL, V_TOTAL) or any interval parameter is 0.

Decomposition:
- Shared package vga_timing_pkg:
  - Localparams for the 640x480@60 default timing.
  - Polarity constants ACTIVE_LOW = 0, ACTIVE_HIGH = 1.
  - Derived-total functions for H_TOTAL and V_TOTAL.
- One natural sub-module: timing_axis.
  - Parameters: ACTIVE, FP, SYNC, BP, POL, W.
  - Inputs: clk, reset, advance.
  - Outputs: count, wrap, sync, in_active.
  - Instantiated twice: horizontal with advance = enable; vertical with advance = enable & h_wrap.
- Top level holds the FSM, strobes and frame counter.

Test Plan:
- Reset: hold i_Reset 3 cycles with i_Enable=1 -> col = 0, row = 0, active = 0, hsync = vsync = 1, strobes 0, frame_count = 0.
- Start: release reset -> first edge gives (0,0), active = 1, line_start = frame_start = 1; next edge gives col 1 with strobes 0.
- Hsync window: run one line -> o_h_sync low exactly at cols 656..751 (96 cycles); active falls at col 640; line_start at col 0 only; col 799 -> 0 with row incremented.
- Frame wrap: run 420000 cycles -> vsync low for rows 490..491; (799,524) -> (0,0) with frame_start = 1 and frame_count = 1.
- Enable pause and mid-frame reset: drop i_Enable for 5 cycles at (700,100) -> all hold, strobes 0; assert reset at (300,200) -> reset values; restart as in the Start scenario.
- Small raster (H 4/1/2/1, V 3/1/1/1, H_POL = V_POL = 1, FRAME_W = 2): run 5 frames -> line period 8, frame period 48, hsync high at cols 5..6, frame_count sequence 1, 2, 3, 0, 1.
